// File: rtl/fft16_frame_ctrl_if.sv
// Control/address bundle between the FFT frame sequencer, the sample stream
// endpoints and the FFT core. master = sequencer side, slave = environment.
interface fft16_frame_ctrl_if #(
   parameter int ADDR_W  = 4,
   parameter int STAGE_W = 1
);
   // input stream
   logic               in_valid;
   logic               in_ready;
   logic               in_last;
   // sample buffer write side
   logic               buf_we;
   logic [ADDR_W-1:0]  buf_waddr;
   // core stage control
   logic               core_start;
   logic [STAGE_W-1:0] core_stage;
   logic               core_done;
   // result read side / output stream
   logic [ADDR_W-1:0]  buf_raddr;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   // status
   logic               busy;
   logic               frame_done;
   logic               err;

   modport master (
      input  in_valid, in_last, core_done, out_ready,
      output in_ready, buf_we, buf_waddr, core_start, core_stage,
             buf_raddr, out_valid, out_last, busy, frame_done, err
   );

   modport slave (
      output in_valid, in_last, core_done, out_ready,
      input  in_ready, buf_we, buf_waddr, core_start, core_stage,
             buf_raddr, out_valid, out_last, busy, frame_done, err
   );
endinterface

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point radix-4 FFT: loads a frame, runs each
// butterfly stage under a watchdog, then unloads results in natural order.
module fft16_frame_ctrl #(
   parameter int N_PTS      = 16,
   parameter int ADDR_W     = 4,
   parameter int NUM_STAGES = 2,
   parameter int TIMEOUT    = 64,
   parameter int REORDER    = 1
) (
   input logic                 clk,
   input logic                 reset,
   fft16_frame_ctrl_if.master  bus
);

   localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int WDOG_W  = $clog2(TIMEOUT) + 1;

   localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(N_PTS - 1);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
   localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      LOAD,
      RUN,
      WAIT,
      UNLOAD
   } state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   wcnt, wcnt_d;
   logic [ADDR_W-1:0]   rcnt, rcnt_d;
   logic [STAGE_W-1:0]  stage, stage_d;
   logic [WDOG_W-1:0]   wdog, wdog_d;
   logic [WDOG_W-1:0]   wdog_inc;
   logic                err_q, err_d;
   logic                done_q, done_d;

   logic                in_ready_c;
   logic                buf_we_c;
   logic                core_start_c;
   logic                out_valid_c;
   logic                out_last_c;
   logic [ADDR_W-1:0]   raddr_c;

   // Base-4 digit reversal: the radix-4 core leaves results in digit-reversed slots.
   function automatic logic [ADDR_W-1:0] digit_rev(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int d = 0; d < ADDR_W / 2; d++)
         r[2*d +: 2] = a[ADDR_W-2-2*d +: 2];
      return r;
   endfunction

   assign wdog_inc = wdog + 1'b1;
   assign raddr_c  = (REORDER != 0) ? digit_rev(rcnt) : rcnt;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state;
      wcnt_d       = wcnt;
      rcnt_d       = rcnt;
      stage_d      = stage;
      wdog_d       = wdog;
      err_d        = err_q;
      done_d       = 1'b0;
      in_ready_c   = 1'b0;
      buf_we_c     = 1'b0;
      core_start_c = 1'b0;
      out_valid_c  = 1'b0;
      out_last_c   = 1'b0;

      unique case (state)
         LOAD: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               buf_we_c = 1'b1;
               wcnt_d   = wcnt + 1'b1;
               if (bus.in_last != (wcnt == LAST_IDX))
                  err_d = 1'b1;
               if (wcnt == LAST_IDX) begin
                  stage_d = '0;
                  state_d = RUN;
               end
            end
         end

         RUN: begin
            core_start_c = 1'b1;
            wdog_d       = '0;
            state_d      = WAIT;
         end

         WAIT: begin
            if (bus.core_done) begin
               if (stage == LAST_STAGE) begin
                  rcnt_d  = '0;
                  state_d = UNLOAD;
               end else begin
                  stage_d = stage + 1'b1;
                  state_d = RUN;
               end
            end else if (wdog_inc == WDOG_LIMIT) begin
               // Abort as the watchdog would reach TIMEOUT-1; the frame is dropped.
               err_d   = 1'b1;
               wcnt_d  = '0;
               state_d = LOAD;
            end else begin
               wdog_d = wdog_inc;
            end
         end

         UNLOAD: begin
            out_valid_c = 1'b1;
            out_last_c  = (rcnt == LAST_IDX);
            if (bus.out_ready) begin
               rcnt_d = rcnt + 1'b1;
               if (rcnt == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = LOAD;
               end
            end
         end

         default: state_d = LOAD;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= LOAD;
         wcnt   <= '0;
         rcnt   <= '0;
         stage  <= '0;
         wdog   <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_d;
         wcnt   <= wcnt_d;
         rcnt   <= rcnt_d;
         stage  <= stage_d;
         wdog   <= wdog_d;
         err_q  <= err_d;
         done_q <= done_d;
      end
   end

   // Outputs are forced low for as long as reset is held, not just after the edge.
   assign bus.in_ready   = reset & in_ready_c;
   assign bus.buf_we     = reset & buf_we_c;
   assign bus.buf_waddr  = (reset && state == LOAD) ? wcnt : '0;
   assign bus.core_start = reset & core_start_c;
   assign bus.core_stage = reset ? stage : '0;
   assign bus.buf_raddr  = (reset && out_valid_c) ? raddr_c : '0;
   assign bus.out_valid  = reset & out_valid_c;
   assign bus.out_last   = reset & out_last_c;
   assign bus.busy       = reset & ((state != LOAD) | (wcnt != '0));
   assign bus.frame_done = reset & done_q;
   assign bus.err        = reset & err_q;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Scoreboard bench for fft16_frame_ctrl: expected write/read addresses and
// stage indices are queued as frames are driven and checked as the DUT acts.
module tb_fft16_frame_ctrl;

   localparam int TIMEOUT  = 64;
   localparam int CORE_LAT = 5;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fft16_frame_ctrl_if bus_if ();

   logic done_model = 1'b0;
   logic done_spur  = 1'b0;
   assign bus_if.core_done = done_model | done_spur;

   fft16_frame_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct packed {
      logic [3:0] addr;
      logic       last;
   } rd_exp_t;

   logic [3:0] exp_waddr[$];
   rd_exp_t    exp_rd[$];
   logic       exp_stage[$];

   int n_checks  = 0;
   int n_fail    = 0;
   int frame_cnt = 0;
   int rd_hs     = 0;
   int ph        = 0;
   bit core_en   = 1'b1;
   bit out_mode  = 1'b0;

   // monitor-owned state
   bit         prev_last_acc, prev_done, prev_stall, prev_hs_last;
   bit         cur_last_acc, cur_hs_last;
   logic [3:0] prev_raddr, mon_w;
   logic       prev_olast;
   rd_exp_t    mon_r;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output-side monitor: write addresses, latencies, read order, stall holding.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_last_acc = 0; prev_done = 0; prev_stall = 0; prev_hs_last = 0;
         end else begin
            cur_last_acc = 0;
            cur_hs_last  = 0;
            if (bus_if.buf_we) begin
               if (exp_waddr.size() == 0) check("we_unexpected", 1, 0);
               else begin
                  mon_w = exp_waddr.pop_front();
                  check("buf_waddr", bus_if.buf_waddr, mon_w);
                  cur_last_acc = (mon_w == 4'd15);
               end
            end
            if (prev_last_acc) check("start_latency", bus_if.core_start, 1);
            if (prev_done) check("done_latency", bus_if.core_start | bus_if.out_valid, 1);
            if (prev_stall) begin
               check("ovalid_hold", bus_if.out_valid, 1);
               check("raddr_hold", bus_if.buf_raddr, prev_raddr);
               check("olast_hold", bus_if.out_last, prev_olast);
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
               rd_hs++;
               if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
               else begin
                  mon_r = exp_rd.pop_front();
                  check("buf_raddr", bus_if.buf_raddr, mon_r.addr);
                  check("out_last", bus_if.out_last, mon_r.last);
                  cur_hs_last = mon_r.last;
               end
            end
            if (bus_if.frame_done || prev_hs_last)
               check("frame_done", bus_if.frame_done, prev_hs_last);
            if (prev_hs_last) check("in_ready_next", bus_if.in_ready, 1);
            if (bus_if.frame_done) frame_cnt++;
            prev_last_acc = cur_last_acc;
            prev_done     = done_model;
            prev_stall    = bus_if.out_valid && !bus_if.out_ready;
            prev_raddr    = bus_if.buf_raddr;
            prev_olast    = bus_if.out_last;
            prev_hs_last  = cur_hs_last;
         end
      end
   end

   // Core model: checks the stage index, answers core_done CORE_LAT cycles after start.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && bus_if.core_start) begin
            if (exp_stage.size() == 0) check("start_unexpected", 1, 0);
            else check("core_stage", bus_if.core_stage, exp_stage.pop_front());
            if (core_en) begin
               repeat (CORE_LAT) @(posedge clk);
               #1 done_model = 1'b1;
               @(posedge clk);
               #1 done_model = 1'b0;
            end
         end
      end
   end

   // Sink: always ready, or the repeating 1,0,0 backpressure pattern.
   initial begin
      bus_if.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (out_mode) begin
            bus_if.out_ready = (ph == 0);
            ph = (ph + 1) % 3;
         end else begin
            bus_if.out_ready = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got t=%0t expected completion", $time);
      $fatal(1, "simulation budget exceeded");
   end

   task automatic send_beat(input logic last);
      int n = 0;
      bus_if.in_valid = 1'b1;
      bus_if.in_last  = last;
      @(negedge clk);
      while (!bus_if.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("in_ready_wait", 0, 1);
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
   endtask

   task automatic send_frame(input int err_beat, input bit gaps, input bit expect_out);
      for (int i = 0; i < 16; i++) exp_waddr.push_back(4'(i));
      exp_stage.push_back(1'b0);
      if (expect_out) begin
         exp_stage.push_back(1'b1);
         for (int i = 0; i < 16; i++)
            exp_rd.push_back(rd_exp_t'{addr: 4'((i % 4) * 4 + i / 4), last: (i == 15)});
      end
      for (int i = 0; i < 16; i++) begin
         if (gaps && (i % 3 == 1)) begin
            repeat (2) begin
               @(negedge clk);
               check("we_gap", bus_if.buf_we, 0);
               check("busy_load", bus_if.busy, 1);
               @(posedge clk);
               #1;
            end
         end
         if (i == err_beat) begin
            @(negedge clk);
            check("err_before", bus_if.err, 0);
            @(posedge clk);
            #1;
         end
         send_beat((err_beat >= 0) ? (i == err_beat) : (i == 15));
         if (i == err_beat) begin
            @(negedge clk);
            check("err_set", bus_if.err, 1);
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_frame(input int start);
      int n = 0;
      while (frame_cnt == start && n < 600) begin
         @(posedge clk);
         n++;
      end
      check("frame_wait", (n < 600), 1);
      #1;
   endtask

   task automatic run_frame(input int err_beat, input bit gaps, input bit bp, input bit exp_err);
      int start = frame_cnt;
      out_mode = bp;
      send_frame(err_beat, gaps, 1'b1);
      wait_frame(start);
      out_mode = 1'b0;
      check("waddr_drained", exp_waddr.size(), 0);
      check("raddr_drained", exp_rd.size(), 0);
      check("stage_drained", exp_stage.size(), 0);
      check("err_after_frame", bus_if.err, exp_err);
      check("busy_idle", bus_if.busy, 0);
   endtask

   initial begin
      int base;
      int n;
      // reset held with in_valid and core_done asserted
      bus_if.in_valid = 1'b1;
      bus_if.in_last  = 1'b0;
      done_spur       = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_in_ready", bus_if.in_ready, 0);
         check("rst_buf_we", bus_if.buf_we, 0);
         check("rst_core_start", bus_if.core_start, 0);
         check("rst_out_valid", bus_if.out_valid, 0);
         check("rst_err", bus_if.err, 0);
      end
      @(posedge clk);
      #1;
      reset           = 1'b1;
      bus_if.in_valid = 1'b0;
      done_spur       = 1'b0;
      @(negedge clk);
      check("release_in_ready", bus_if.in_ready, 1);
      check("release_busy", bus_if.busy, 0);
      @(posedge clk);
      #1;

      // nominal frames, then backpressure with input gaps
      run_frame(-1, 1'b0, 1'b0, 1'b0);
      run_frame(-1, 1'b0, 1'b0, 1'b0);
      run_frame(-1, 1'b1, 1'b1, 1'b0);

      // watchdog: core never answers stage 0
      core_en = 1'b0;
      send_frame(-1, 1'b0, 1'b0);
      @(negedge clk);
      check("to_core_start", bus_if.core_start, 1);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("to_in_ready_early", bus_if.in_ready, 0);
      check("to_err_early", bus_if.err, 0);
      @(negedge clk);
      check("to_in_ready", bus_if.in_ready, 1);
      check("to_err", bus_if.err, 1);
      check("to_busy", bus_if.busy, 0);
      check("to_stage_drained", exp_stage.size(), 0);
      core_en = 1'b1;

      // spurious core_done while loading
      @(posedge clk);
      #1 done_spur = 1'b1;
      @(negedge clk);
      check("spur_no_start", bus_if.core_start, 0);
      @(posedge clk);
      #1 done_spur = 1'b0;
      @(negedge clk);
      check("spur_no_start_next", bus_if.core_start, 0);
      check("spur_in_ready", bus_if.in_ready, 1);

      // clear the sticky error, then in_last on beat 9
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("err_cleared", bus_if.err, 0);
      @(posedge clk);
      #1;
      run_frame(8, 1'b0, 1'b0, 1'b1);
      run_frame(-1, 1'b0, 1'b0, 1'b1);

      // reset in the middle of unload (rcnt = 7)
      base = rd_hs;
      n    = 0;
      send_frame(-1, 1'b0, 1'b1);
      while (rd_hs < base + 7 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check("mid_unload_reach", (n < 300), 1);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", bus_if.out_valid, 0);
      check("mid_rst_err", bus_if.err, 0);
      check("mid_rst_busy", bus_if.busy, 0);
      exp_rd.delete();
      exp_waddr.delete();
      exp_stage.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("mid_rel_in_ready", bus_if.in_ready, 1);
      check("mid_rel_err", bus_if.err, 0);
      @(posedge clk);
      #1;
      run_frame(-1, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
